jk_seq_driver: RTL and testbench

//  Drives J/K inputs of an external bank of WIDTH jkff instances so the bank steps through a

---
 rtl/jk_seq_driver.sv | 205 ++++++++++++++++++++
 tb/tb_jk_seq_driver.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_seq_driver.sv
// -----------------------------------------------------------------------------
// jk_seq_driver
//
// Purpose:
//   Drives the J/K inputs of an external bank of WIDTH JK flip-flops so that
//   the bank walks through a programmed sequence of target states. The bank's
//   q outputs come back on q_fb. After each step they are compared with the
//   target, so the block is both a JK excitation source and a JK bank self-test.
//
//   Each table entry takes three cycles:
//     DRIVE  : the excitation is computed from the current q_fb and registered.
//     SETTLE : j/k are presented to the bank, which samples them at the
//              closing edge. j/k are cleared at that same edge.
//     CHECK  : q_fb now holds the bank's new state and is compared with the
//              target entry.
//
//   Outside SETTLE, j and k are always 0/0, so the bank holds its state.
//
// Ports:
//   clk       in   1        rising-edge clock
//   reset     in   1        asynchronous, active-high; clears outputs, FSM, table
//   wr_en     in   1        table write strobe (honoured only when not busy)
//   wr_addr   in   AW       table write address
//   wr_data   in   WIDTH    target state to store
//   seq_len   in   AW+1     entries to run, sampled with start; >DEPTH clamps
//   start     in   1        begin a run at entry 0 (ignored if seq_len == 0)
//   stop      in   1        abort to IDLE from any state; beats start
//   loop      in   1        sampled in CHECK of the last entry; 1 = wrap to 0
//   q_fb      in   WIDTH    q outputs of the external JK bank
//   j, k      out  WIDTH    registered J/K drive
//   busy      out  1        high in DRIVE/SETTLE/CHECK
//   done      out  1        high in DONE
//   mismatch  out  1        high in ERROR
//   step_idx  out  AW       current entry; in ERROR, the failing entry
// -----------------------------------------------------------------------------
module jk_seq_driver #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW:0]      seq_len,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [AW-1:0]    step_idx
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam logic [AW:0]   DEPTH_LEN = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_MAX  = AW'(DEPTH - 1);

  // FSM state. The bench and checkers probe this signal hierarchically.
  state_t state;

  // Sequence table and the index of the last entry in the current run.
  logic [WIDTH-1:0] table_q [DEPTH];
  logic [AW-1:0]    last_idx;

  // Derived signals.
  logic             idle_like;
  logic [AW-1:0]    start_last;
  logic [WIDTH-1:0] cur_t;

  // The table may only be written while no run is in flight.
  always_comb begin
    idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  end

  // Clamp the requested length to DEPTH. Only the last index is kept, so a
  // length of DEPTH still fits in AW bits. seq_len == 0 never reaches this
  // value, because start is ignored in that case.
  always_comb begin
    if (seq_len > DEPTH_LEN) begin
      start_last = LAST_MAX;
    end else begin
      start_last = AW'(seq_len - (AW+1)'(1));
    end
  end

  always_comb begin
    cur_t = table_q[step_idx];
  end

  // Table storage. A write on the same edge as start lands before DRIVE reads
  // entry 0 on the following cycle, so that entry 0 already sees the new data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else if (wr_en && idle_like) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      j        <= '0;
      k        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mismatch <= 1'b0;
      step_idx <= '0;
      last_idx <= '0;
    end else if (stop) begin
      // Abort takes priority over everything else, including start.
      state    <= S_IDLE;
      j        <= '0;
      k        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mismatch <= 1'b0;
      step_idx <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start && (seq_len != '0)) begin
            state    <= S_DRIVE;
            step_idx <= '0;
            last_idx <= start_last;
            busy     <= 1'b1;
            done     <= 1'b0;
            mismatch <= 1'b0;
          end
        end

        S_DRIVE: begin
          // Set only the bits that must rise, and reset only the bits that
          // must fall. Bits already at target get 0/0 (hold). A bit never
          // gets 1/1, so the bank's toggle mode is never used.
          j     <= cur_t & ~q_fb;
          k     <= ~cur_t & q_fb;
          state <= S_SETTLE;
        end

        S_SETTLE: begin
          // The bank samples j/k at this edge. Drop the drive at the same edge.
          j     <= '0;
          k     <= '0;
          state <= S_CHECK;
        end

        S_CHECK: begin
          if (q_fb != cur_t) begin
            // step_idx is held so that it identifies the failing entry.
            state    <= S_ERROR;
            busy     <= 1'b0;
            mismatch <= 1'b1;
          end else if (step_idx == last_idx) begin
            if (loop) begin
              step_idx <= '0;
              state    <= S_DRIVE;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            step_idx <= step_idx + AW'(1);
            state    <= S_DRIVE;
          end
        end

        default: begin
          state    <= S_IDLE;
          j        <= '0;
          k        <= '0;
          busy     <= 1'b0;
          done     <= 1'b0;
          mismatch <= 1'b0;
          step_idx <= '0;
        end
      endcase
    end
  end

  // A JK flip-flop must never see J and K high together from this driver.
  a_no_toggle_drive: assert property (@(posedge clk) disable iff (reset) (j & k) == '0);

  // j/k may be non-zero only while the bank is sampling them.
  a_drive_only_in_settle: assert property (@(posedge clk) disable iff (reset)
    (state != S_SETTLE) |-> ((j | k) == '0));

endmodule

// File: tb/tb_jk_seq_driver.sv
// -----------------------------------------------------------------------------
// tb_jk_seq_driver
//
// Bench for jk_seq_driver. The bench contains a bank of WIDTH JK flip-flops.
// The bank is driven by the DUT's j/k, and its q is fed back on q_fb. An
// optional stuck-at-0 mask can be applied to the fed-back q.
//
// The expected values come from a short description of the intended
// behaviour:
//   - each table entry takes three cycles: DRIVE, SETTLE, CHECK;
//   - in SETTLE, j = target & ~previous and k = ~target & previous;
//   - in CHECK, the bank shows the target value;
//   - after the last entry the DUT reports done.
// -----------------------------------------------------------------------------
module tb_jk_seq_driver;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int AW = 3;

  // Clock and reset.
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT inputs and outputs.
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [AW:0]   seq_len;
  logic          start, stop, loop;
  logic [W-1:0]  q_fb, j, k;
  logic          busy, done, mismatch;
  logic [AW-1:0] step_idx;

  jk_seq_driver #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .seq_len(seq_len), .start(start), .stop(stop), .loop(loop), .q_fb(q_fb),
    .j(j), .k(k), .busy(busy), .done(done), .mismatch(mismatch), .step_idx(step_idx)
  );

  // External JK bank. bank_load preloads an arbitrary state.
  logic [W-1:0] bank_q, bank_val, stuck_mask;
  logic         bank_load;
  always @(posedge clk) begin
    if (bank_load) bank_q <= bank_val;
    else begin
      for (int i = 0; i < W; i++) begin
        case ({j[i], k[i]})
          2'b10:   bank_q[i] <= 1'b1;
          2'b01:   bank_q[i] <= 1'b0;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: bank_q[i] <= bank_q[i];
        endcase
      end
    end
  end
  assign q_fb = bank_q & ~stuck_mask;

  // Scoreboard state: the expected table contents and the check counters.
  logic [W-1:0] mtab [D];
  int n_pass  = 0;
  int n_total = 0;

  // Time limit for the whole run.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Driver tasks. Inputs change 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_bank(input logic [W-1:0] v);
    bank_load = 1'b1; bank_val = v;
    tick();
    bank_load = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenario tasks.
  // ---------------------------------------------------------------------------

  // Runs one non-looping sequence and checks every cycle against the model.
  // If wr0 is set, entry 0 is written on the same edge as start.
  task automatic test_sequence(input string name, input int len_in, input logic [W-1:0] init_q,
                               input bit wr0, input logic [W-1:0] wr0_data);
    int eff;
    logic [W-1:0] p, t, ej, ek;
    load_bank(init_q);
    eff = (len_in > D) ? D : len_in;
    seq_len = (AW+1)'(len_in); loop = 1'b0; start = 1'b1;
    if (wr0) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = wr0_data;
      mtab[0] = wr0_data;
    end
    tick();
    start = 1'b0; wr_en = 1'b0;
    p = init_q;
    for (int e = 0; e < eff; e++) begin
      t = mtab[e];
      for (int ph = 0; ph < 3; ph++) begin
        @(negedge clk);
        ej = (ph == 1) ? (t & ~p) : '0;
        ek = (ph == 1) ? (~t & p) : '0;
        n_total++;
        if ({busy, done, mismatch, step_idx, j, k} !== {1'b1, 1'b0, 1'b0, AW'(e), ej, ek})
          $display("FAIL %s step%0d ph%0d: busy/done/mis/idx/j/k got %b%b%b %0d %b %b, expected 100 %0d %b %b",
                   name, e, ph, busy, done, mismatch, step_idx, j, k, e, ej, ek);
        else n_pass++;
        if (ph == 2) begin
          n_total++;
          if (q_fb !== t) $display("FAIL %s q_fb at step%0d: got %b expected %b", name, e, q_fb, t);
          else n_pass++;
          p = t;
        end
        tick();
      end
    end
    @(negedge clk);
    n_total++;
    if ({busy, done, mismatch, j, k} !== {3'b010, {W{1'b0}}, {W{1'b0}}})
      $display("FAIL %s end: busy/done/mis/j/k got %b%b%b %b %b expected 010 0 0",
               name, busy, done, mismatch, j, k);
    else n_pass++;
    tick();
  endtask

  // Checks the reset values of all outputs.
  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_total++;
    if ({busy, done, mismatch, step_idx, j, k} !== '0)
      $display("FAIL reset_values: got %b%b%b %0d %b %b expected all zero", busy, done, mismatch, step_idx, j, k);
    else n_pass++;
    #2 reset = 1'b0;
    tick();
  endtask

  // Checks that start is ignored when seq_len is 0, and that stop beats start.
  task automatic test_start_guard();
    seq_len = '0; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL zero_len_start: busy got %b expected 0", busy);
    else n_pass++;
    tick();
    seq_len = 4; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    n_total++;
    if ({busy, done, mismatch, step_idx} !== '0)
      $display("FAIL stop_beats_start: got %b%b%b %0d expected idle zeros", busy, done, mismatch, step_idx);
    else n_pass++;
    tick();
  endtask

  // Fills the whole table with random values.
  task automatic fill_random();
    for (int i = 0; i < D; i++) begin
      mtab[i] = W'($urandom);
      write_entry(AW'(i), mtab[i]);
    end
  endtask

  // Forces bit 0 of q_fb stuck at 0. The run must stop at the first entry whose
  // target needs bit 0 set.
  task automatic test_mismatch(input int force_at);
    int fi, lim;
    fill_random();
    for (int i = 0; i < force_at; i++) begin
      mtab[i][0] = 1'b0;
      write_entry(AW'(i), mtab[i]);
    end
    mtab[force_at][0] = 1'b1;
    write_entry(AW'(force_at), mtab[force_at]);
    fi = -1;
    for (int i = 0; i < 4; i++) if (fi < 0 && mtab[i][0]) fi = i;
    load_bank('0);
    stuck_mask = 'b1;
    seq_len = 4; loop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    lim = 3 * (fi + 1);
    for (int c = 0; c < lim; c++) tick();
    @(negedge clk);
    n_total++;
    if ({busy, done, mismatch, step_idx, j, k} !== {3'b001, AW'(fi), {W{1'b0}}, {W{1'b0}}})
      $display("FAIL mismatch_flag: got %b%b%b idx %0d j %b k %b expected 001 idx %0d j 0 k 0",
               busy, done, mismatch, step_idx, j, k, fi);
    else n_pass++;
    tick(); tick(); tick();
    @(negedge clk);
    n_total++;
    if ({mismatch, step_idx} !== {1'b1, AW'(fi)})
      $display("FAIL mismatch_hold: got %b idx %0d expected 1 idx %0d", mismatch, step_idx, fi);
    else n_pass++;
    tick();
    stuck_mask = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    n_total++;
    if ({busy, mismatch, step_idx} !== {2'b10, AW'(0)})
      $display("FAIL start_clears_mismatch: busy/mis/idx got %b%b %0d expected 10 0", busy, mismatch, step_idx);
    else n_pass++;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Runs with loop=1 and seq_len=3. Checks the index order 0,1,2,0,1, then
  // applies stop in DRIVE of the second entry 1.
  task automatic test_loop_stop();
    logic [W-1:0] p, t, ej, ek;
    mtab[0] = 4'd3; mtab[1] = 4'd5; mtab[2] = 4'd6;
    for (int i = 0; i < 3; i++) write_entry(AW'(i), mtab[i]);
    load_bank('0);
    p = '0;
    seq_len = 3; loop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 0; e < 5; e++) begin
      t = mtab[e % 3];
      for (int ph = 0; ph < 3; ph++) begin
        @(negedge clk);
        ej = (ph == 1) ? (t & ~p) : '0;
        ek = (ph == 1) ? (~t & p) : '0;
        n_total++;
        if ({busy, step_idx, j, k} !== {1'b1, AW'(e % 3), ej, ek})
          $display("FAIL loop pass%0d ph%0d: busy/idx/j/k got %b %0d %b %b expected 1 %0d %b %b",
                   e, ph, busy, step_idx, j, k, e % 3, ej, ek);
        else n_pass++;
        if (ph == 2) p = t;
        if (e == 4 && ph == 0) begin
          stop = 1'b1;
          tick();
          stop = 1'b0;
          @(negedge clk);
          n_total++;
          if ({busy, done, mismatch, step_idx, j, k} !== '0)
            $display("FAIL stop_in_loop: got %b%b%b %0d %b %b expected all zero",
                     busy, done, mismatch, step_idx, j, k);
          else n_pass++;
          break;
        end
        tick();
      end
    end
    loop = 1'b0;
    tick();
  endtask

  // Writes entry 2 while the DUT is busy. The write must be ignored, which
  // the readback run then confirms.
  task automatic test_busy_write();
    bit seen;
    fill_random();
    load_bank('0);
    seq_len = 4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wr_en = 1'b1; wr_addr = 2; wr_data = ~mtab[2];
    tick();
    wr_en = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      tick();
    end
    n_total++;
    if (!seen) $display("FAIL busy_write_run_done: done got %b within 40 cycles, expected 1", done);
    else n_pass++;
    test_sequence("busy_write_readback", 4, W'($urandom), 1'b0, '0);
  endtask

  // Applies reset asynchronously during SETTLE, then checks that the table
  // has been cleared.
  task automatic test_reset_mid();
    fill_random();
    mtab[0] = mtab[0] | 4'b0001;
    write_entry(0, mtab[0]);
    load_bank('0);
    seq_len = 4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    n_total++;
    if (j !== mtab[0]) $display("FAIL settle_before_reset: j got %b expected %b", j, mtab[0]);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if ({busy, done, mismatch, step_idx, j, k} !== '0)
      $display("FAIL async_reset_mid: got %b%b%b %0d %b %b expected all zero",
               busy, done, mismatch, step_idx, j, k);
    else n_pass++;
    #1 reset = 1'b0;
    for (int i = 0; i < D; i++) mtab[i] = '0;
    tick();
    test_sequence("post_reset_table", D, 4'hF, 1'b0, '0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence and final report.
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    seq_len = '0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    bank_load = 1'b1; bank_val = '0; stuck_mask = '0;
    for (int i = 0; i < D; i++) mtab[i] = '0;
    test_reset();
    bank_load = 1'b0;

    test_start_guard();

    mtab[0] = 4'd1; mtab[1] = 4'd2; mtab[2] = 4'd4; mtab[3] = 4'd8;
    for (int i = 0; i < 4; i++) write_entry(AW'(i), mtab[i]);
    test_sequence("one_hot_walk", 4, 4'b0000, 1'b0, '0);

    mtab[0] = 4'b1010;
    write_entry(0, mtab[0]);
    test_sequence("jk_excitation", 1, 4'b0110, 1'b0, '0);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      test_sequence("random_run", $urandom_range(15, 1), W'($urandom), 1'b0, '0);
    end
    fill_random();
    test_sequence("len_clamp", 12, W'($urandom), 1'b0, '0);

    fill_random();
    test_sequence("write_with_start", 2, W'($urandom), 1'b1, ~mtab[0]);

    test_mismatch(0);
    test_mismatch(2);
    test_loop_stop();
    test_busy_write();
    test_reset_mid();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
